// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear controller for a two-digit BCD stopwatch.
// Rising edges on three buttons drive an IDLE/RUN/PAUSE/DONE state machine.
// A 24-bit prescaler gates count steps on a ones/tens BCD pair.
// A lap flag freezes the displayed value on a snapshot while the live count
// keeps advancing underneath. All outputs are registered and trail the
// internal state by one cycle.

module stopwatch_ctrl #(
   parameter int unsigned TICK_DIV  = 32'd8388608,
   parameter bit          WRAP_MODE = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_start_stop,
   input  logic       btn_clear,
   input  logic       btn_lap,
   output logic [3:0] ones_bcd,
   output logic [3:0] tens_bcd,
   output logic       running,
   output logic       lap_active,
   output logic       wrap_pulse
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Terminal prescaler value; the step fires in the cycle the prescaler sits here.
   localparam logic [23:0] PRESC_LAST = 24'(TICK_DIV - 32'd1);

   // Next {tens, ones} after one count step. 99 folds to 00; the caller
   // decides whether that fold is a wrap or a stop.
   function automatic logic [7:0] bcd_step(input logic [3:0] tens, input logic [3:0] ones);
      logic [7:0] nxt;
      if (ones < 4'd9) begin
         nxt = {tens, ones + 4'd1};
      end else if (tens < 4'd9) begin
         nxt = {tens + 4'd1, 4'd0};
      end else begin
         nxt = 8'd0;
      end
      return nxt;
   endfunction

   // True when the pair holds 99, i.e. the next step is the wrap/stop step.
   function automatic logic bcd_at_max(input logic [3:0] tens, input logic [3:0] ones);
      return (tens == 4'd9) && (ones == 4'd9);
   endfunction

   state_t      state_r;
   state_t      state_s;

   logic        hist_start_r;
   logic        hist_clear_r;
   logic        hist_lap_r;
   logic        ev_start_s;
   logic        ev_clear_s;
   logic        ev_lap_s;

   logic [23:0] presc_r;
   logic [23:0] presc_s;
   logic        step_s;
   logic        at_max_s;

   logic [3:0]  ones_r;
   logic [3:0]  tens_r;
   logic [3:0]  ones_s;
   logic [3:0]  tens_s;
   logic [3:0]  snap_ones_r;
   logic [3:0]  snap_tens_r;
   logic [3:0]  snap_ones_s;
   logic [3:0]  snap_tens_s;
   logic        lap_r;
   logic        lap_s;
   logic        wrap_r;
   logic        wrap_s;
   logic [7:0]  stepped_s;

   // Button events are rising edges against last cycle's level.
   assign ev_start_s = btn_start_stop & ~hist_start_r;
   assign ev_clear_s = btn_clear      & ~hist_clear_r;
   assign ev_lap_s   = btn_lap        & ~hist_lap_r;

   // A count step happens only while running, on the terminal prescaler cycle.
   assign step_s    = (state_r == ST_RUN) && (presc_r == PRESC_LAST);
   assign at_max_s  = bcd_at_max(tens_r, ones_r);
   assign stepped_s = bcd_step(tens_r, ones_r);

   // Button history; forced high in reset so a held button yields no event.
   always_ff @(posedge clock) begin
      if (reset) begin
         hist_start_r <= 1'b1;
         hist_clear_r <= 1'b1;
         hist_lap_r   <= 1'b1;
      end else begin
         hist_start_r <= btn_start_stop;
         hist_clear_r <= btn_clear;
         hist_lap_r   <= btn_lap;
      end
   end

   // State register of the control FSM.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state plus next prescaler, live count, snapshot, lap flag and wrap strobe.
   always_comb begin
      state_s     = state_r;
      presc_s     = presc_r;
      ones_s      = ones_r;
      tens_s      = tens_r;
      snap_ones_s = snap_ones_r;
      snap_tens_s = snap_tens_r;
      lap_s       = lap_r;
      wrap_s      = 1'b0;

      case (state_r)
         ST_IDLE: begin
            // Clear and lap carry no meaning before the first start.
            if (ev_start_s) begin
               state_s = ST_RUN;
               presc_s = 24'd0;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_RUN: begin
            // The prescaler keeps counting in the cycle a pause is requested,
            // so a pause on the terminal cycle still takes its step.
            if (step_s) begin
               presc_s = 24'd0;
            end else begin
               presc_s = presc_r + 24'd1;
            end

            if (ev_lap_s) begin
               lap_s = ~lap_r;
               if (!lap_r) begin
                  snap_ones_s = ones_r;
                  snap_tens_s = tens_r;
               end else begin
                  snap_ones_s = snap_ones_r;
                  snap_tens_s = snap_tens_r;
               end
            end else begin
               lap_s = lap_r;
            end

            if (step_s && at_max_s) begin
               wrap_s = 1'b1;
               if (WRAP_MODE) begin
                  ones_s = 4'd0;
                  tens_s = 4'd0;
               end else begin
                  ones_s = ones_r;
                  tens_s = tens_r;
               end
            end else if (step_s) begin
               ones_s = stepped_s[3:0];
               tens_s = stepped_s[7:4];
            end else begin
               ones_s = ones_r;
               tens_s = tens_r;
            end

            // Reaching 99 without wrap ends the run even if start is pressed too.
            if (step_s && at_max_s && !WRAP_MODE) begin
               state_s = ST_DONE;
            end else if (ev_start_s) begin
               state_s = ST_PAUSE;
            end else begin
               state_s = ST_RUN;
            end
         end

         ST_PAUSE: begin
            if (ev_clear_s) begin
               state_s = ST_IDLE;
               presc_s = 24'd0;
               ones_s  = 4'd0;
               tens_s  = 4'd0;
               lap_s   = 1'b0;
            end else begin
               // Resume keeps the retained prescaler value.
               if (ev_start_s) begin
                  state_s = ST_RUN;
               end else begin
                  state_s = ST_PAUSE;
               end
               // Lap can only release a freeze here, never start one.
               if (ev_lap_s && lap_r) begin
                  lap_s = 1'b0;
               end else begin
                  lap_s = lap_r;
               end
            end
         end

         ST_DONE: begin
            // Count stays parked at 99; start is ignored.
            if (ev_clear_s) begin
               state_s = ST_IDLE;
               presc_s = 24'd0;
               ones_s  = 4'd0;
               tens_s  = 4'd0;
               lap_s   = 1'b0;
            end else if (ev_lap_s && lap_r) begin
               state_s = ST_DONE;
               lap_s   = 1'b0;
            end else begin
               state_s = ST_DONE;
               lap_s   = lap_r;
            end
         end

         default: begin
            state_s = ST_IDLE;
            presc_s = 24'd0;
            ones_s  = 4'd0;
            tens_s  = 4'd0;
            lap_s   = 1'b0;
         end
      endcase
   end

   // Datapath registers: prescaler, live count, lap snapshot, lap flag, wrap strobe.
   always_ff @(posedge clock) begin
      if (reset) begin
         presc_r     <= 24'd0;
         ones_r      <= 4'd0;
         tens_r      <= 4'd0;
         snap_ones_r <= 4'd0;
         snap_tens_r <= 4'd0;
         lap_r       <= 1'b0;
         wrap_r      <= 1'b0;
      end else begin
         presc_r     <= presc_s;
         ones_r      <= ones_s;
         tens_r      <= tens_s;
         snap_ones_r <= snap_ones_s;
         snap_tens_r <= snap_tens_s;
         lap_r       <= lap_s;
         wrap_r      <= wrap_s;
      end
   end

   // Output stage: display mux and status copies, one cycle behind the internals.
   always_ff @(posedge clock) begin
      if (reset) begin
         ones_bcd   <= 4'd0;
         tens_bcd   <= 4'd0;
         running    <= 1'b0;
         lap_active <= 1'b0;
         wrap_pulse <= 1'b0;
      end else begin
         ones_bcd   <= lap_r ? snap_ones_r : ones_r;
         tens_bcd   <= lap_r ? snap_tens_r : tens_r;
         running    <= (state_r == ST_RUN);
         lap_active <= lap_r;
         wrap_pulse <= wrap_r;
      end
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Run/pause/clear controller for the two-digit BCD seven-segment counter datapath.
- Detects rising edges on three button inputs and sequences a 4-state FSM.
- Gates a tick prescaler and steps a ones/tens BCD pair (00..99).
- Supports a lap-freeze of the displayed value; BCD outputs feed the existing seven-segment decoders.

Parameters:
- TICK_DIV, 8388608, clock cycles per count step; legal range 2..2^24-1. The prescaler is 24 bits wide.
- WRAP_MODE, 1, 1 = roll over 99->00 and keep running; 0 = stop at 99 in DONE.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- btn_start_stop  in  1  level, already synchronous to clock; rising edge toggles run/pause.
- btn_clear  in  1  level, synchronous; rising edge clears when stopped.
- btn_lap  in  1  level, synchronous; rising edge toggles lap freeze.
- ones_bcd  out  4  displayed ones digit, 0..9.
- tens_bcd  out  4  displayed tens digit, 0..9.
- running  out  1  high while state == RUN.
- lap_active  out  1  display frozen at lap snapshot.
- wrap_pulse  out  1  one-cycle strobe on a count step taken from 99.

Behaviour:
- Reset (synchronous, active-high; clock edge with reset=1):
  - state=IDLE; live count=00; snapshot=00; prescaler=0.
  - All outputs 0.
  - Edge-detect history registers are set to 1, so a button held through reset produces no event.
- Edge detect: event = input & ~history; history <= input every cycle. The event is acted on in the same cycle it is detected.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE: start -> RUN with prescaler=0. Clear and lap are ignored.
  - RUN:
    - start -> PAUSE; prescaler holds its value.
    - Clear is ignored.
    - lap toggles lap_active. On 0->1, snapshot <= the live count as of that cycle.
  - PAUSE:
    - clear -> IDLE: live count=00, prescaler=0, lap_active=0.
    - Otherwise start -> RUN, resuming with the retained prescaler value.
    - Clear has priority over start in the same cycle.
    - lap while lap_active=1 -> lap_active=0. A lap with lap_active=0 is ignored.
  - DONE (WRAP_MODE=0 only):
    - Live count held at 99.
    - clear -> IDLE with the same clears as PAUSE.
    - start ignored. lap behaves as in PAUSE.
- Prescaler (counts only in RUN):
  - Increments 0..TICK_DIV-1.
  - At TICK_DIV-1 it returns to 0 and raises an internal step for that cycle.
  - The live count updates on the same clock edge, so it is visible one cycle after the terminal prescaler cycle.
  - If a start event coincides with the terminal cycle, the step is taken and the FSM goes to PAUSE with prescaler=0.
- BCD step:
  - ones<9: ones+1.
  - ones==9, tens<9: ones=0, tens+1.
  - ones==9, tens==9:
    - WRAP_MODE=1: count=00; wrap_pulse=1 for exactly one cycle, registered and aligned with the 00 value; stay in RUN.
    - WRAP_MODE=0: count stays 99; state -> DONE; wrap_pulse=1 for one cycle.
  - Digits never leave 0..9. Internal arithmetic is 4 bits per digit with no binary carry into tens.
- Display outputs (registered, updated every cycle):
  - ones_bcd/tens_bcd = snapshot when lap_active=1, otherwise the live count.
  - Latency is 1 cycle from an internal update to the outputs.
- running and lap_active are registered copies of state/flag, with the same 1-cycle alignment as the BCD outputs.
- Reset asserted mid-RUN or mid-lap: the full reset values apply on the next edge; no pending event survives.

Test Plan:
- Use TICK_DIV=4, WRAP_MODE=1 for all scenarios unless noted.
1. Reset with btn_start_stop held high, then release and press once -> no event during hold; after the press, running=1 one cycle later; ones_bcd=1 after 4 RUN cycles, 2 after 8.
2. Run to 09, then one more step -> ones_bcd=0, tens_bcd=1. Continue to 99, then one step -> 00 with wrap_pulse=1 for exactly one cycle, running still 1.
3. WRAP_MODE=0, run to 99 -> state DONE, running=0, wrap_pulse pulses once, count holds 99. A start press is ignored; a clear press -> 00, IDLE.
4. At count 23 press lap -> outputs hold 23, lap_active=1 while the live count advances to 27. Press lap again -> outputs show the live value (27 or 28) next cycle.
5. Pause at prescaler=2, wait 50 cycles, resume -> next step occurs exactly 2 cycles after resume (prescaler retained). In PAUSE, press start and clear in the same cycle -> IDLE, outputs 00, running=0.
6. Assert reset mid-RUN with lap_active=1 at count 57 -> next edge: outputs 00, lap_active=0, running=0, wrap_pulse=0.
